// File: rtl/demux_pkg.sv
// demux_pkg: shared constants, select-width helper and holding-state type for demux_deser
package demux_pkg;
  localparam int DEMUX_WIDTH_DEF = 8;
  function automatic int sel_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
  typedef enum logic {HOLD_EMPTY, HOLD_FULL} hold_e;
endpackage

// File: rtl/demux_deser_if.sv
// demux_deser_if: serial input, lane select and word valid/ready bundle for demux_deser
interface demux_deser_if #(parameter int WIDTH = demux_pkg::DEMUX_WIDTH_DEF);
  localparam int SEL_W = demux_pkg::sel_w(WIDTH);
  logic din;
  logic din_valid;
  logic sel_load;
  logic [SEL_W-1:0] sel_in;
  logic [SEL_W-1:0] sel_out;
  logic [WIDTH-1:0] lane;
  logic [WIDTH-1:0] word;
  logic word_valid;
  logic word_ready;
  logic overflow;
  logic parity_err;
  modport master(
    output din, din_valid, sel_load, sel_in, word_ready,
    input sel_out, lane, word, word_valid, overflow, parity_err
  );
  modport slave(
    input din, din_valid, sel_load, sel_in, word_ready,
    output sel_out, lane, word, word_valid, overflow, parity_err
  );
endinterface

// File: rtl/demux_hold_reg.sv
// demux_hold_reg: single-entry valid/ready holding register that drops and flags words arriving while full
module demux_hold_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             d_par,
  input  logic             ready,
  output logic [WIDTH-1:0] q,
  output logic             q_par,
  output logic             valid,
  output logic             overflow
);
  hold_e state, state_nxt;
  logic take;
  // A completing frame may replace a word that is leaving in the same cycle
  always_comb begin
    valid = state == HOLD_FULL;
    take = load && (!valid || ready);
    state_nxt = take ? HOLD_FULL : (valid && ready) ? HOLD_EMPTY : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= HOLD_EMPTY;
      q <= '0;
      q_par <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        q <= d;
        q_par <= d_par;
      end
      if (load && !take) overflow <= 1'b1;
    end
  end
endmodule

// File: rtl/demux_deser.sv
// demux_deser: 1:WIDTH serial demux/deserializer with auto-incrementing lane select and held word output
// Optional DEMUX_DESER_PARITY_EN: frame carries a trailing even-parity bit checked into parity_err.
module demux_deser
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH_DEF
) (
  input logic        clk,
  input logic        rst_n,
  demux_deser_if.slave bus
);
  localparam int SEL_W = sel_w(WIDTH);
  localparam int CNT_W = SEL_W + 1;
`ifdef DEMUX_DESER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  logic [SEL_W-1:0] sel;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] asm_r, asm_nxt, onehot;
  logic accept, last, data_bit, done, par_in;
  // The parity bit (when present) leaves sel and the assembly untouched
  always_comb begin
    onehot = WIDTH'(1) << sel;
    accept = bus.din_valid && !bus.sel_load;
    last = cnt == CNT_W'(FRAME - 1);
    data_bit = cnt < CNT_W'(WIDTH);
    asm_nxt = data_bit ? (bus.din ? (asm_r | onehot) : (asm_r & ~onehot)) : asm_r;
    done = accept && last;
`ifdef DEMUX_DESER_PARITY_EN
    par_in = ^asm_r ^ bus.din;
`else
    par_in = 1'b0;
`endif
    bus.lane = (bus.din_valid && bus.din) ? onehot : '0;
    bus.sel_out = sel;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel <= '0;
      cnt <= '0;
      asm_r <= '0;
    end else if (bus.sel_load) begin
      sel <= bus.sel_in;
      cnt <= '0;
      asm_r <= '0;
    end else if (accept) begin
      sel <= data_bit ? sel + 1'b1 : sel;
      cnt <= last ? '0 : cnt + 1'b1;
      asm_r <= last ? '0 : asm_nxt;
    end
  end
  demux_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk(clk),
    .rst_n(rst_n),
    .load(done),
    .d(asm_nxt),
    .d_par(par_in),
    .ready(bus.word_ready),
    .q(bus.word),
    .q_par(bus.parity_err),
    .valid(bus.word_valid),
    .overflow(bus.overflow)
  );
endmodule

// File: doc/demux_deser.md
Name: demux_deser

Overview:
- 1:WIDTH demultiplexer and deserializer; the receive-side counterpart of the 8:1 bit-select mux.
- A serial bit stream `din`, qualified by `din_valid`, is steered to lane `sel` and captured into a shift/assembly register. `sel` auto-increments.
- After WIDTH bits, the assembled word is presented on a valid/ready output port.
- Sits downstream of the mux path in the lane-select datapath, restoring a parallel word from the selected-bit sequence.

Parameters:
- WIDTH, 8, number of lanes / word width; power of two, 2..64.
- SEL_W, $clog2(WIDTH), select width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- din  in  1  serial data bit
- din_valid  in  1  din qualifier; one bit accepted per cycle when high
- sel_load  in  1  load sel_in into the select counter and restart the frame
- sel_in  in  SEL_W  start lane index for sel_load
- sel_out  out  SEL_W  current select counter (lane for the next accepted bit)
- lane  out  WIDTH  combinational demux: lane[sel_out]=din when din_valid, all other bits 0
- word  out  WIDTH  assembled word, stable while word_valid
- word_valid  out  1  holding register full
- word_ready  in  1  consumer accept; transfer when word_valid && word_ready
- overflow  out  1  sticky: completed frame dropped because holding register was full
- parity_err  out  1  parity result for the current word (feature only; else 0)

Behaviour:
- Reset: clk domain only; rst_n sampled at posedge.
  - sel_out=0, assembly reg=0, bit count=0, word=0, word_valid=0, overflow=0, parity_err=0.
  - Mid-frame reset discards partial bits and any held word.
- States: FILL (collecting bits), and the holding register is either EMPTY or FULL. Word handoff completes in the same cycle as the last bit.
- Accept cycle (din_valid=1, sel_load=0):
  - asm[sel_out] <= din.
  - sel_out <= sel_out+1, wrapping WIDTH-1 -> 0.
  - count <= count+1.
- Frame complete: the accept with count==WIDTH-1.
  - Next cycle: word = assembled value including the final bit; word_valid=1; count=0; asm cleared. Latency: last bit -> word_valid = 1 cycle.
- sel_load=1: sel_out <= sel_in, count <= 0, asm cleared; din is ignored that cycle, even if din_valid=1.
  - sel_load has priority over din_valid.
  - Does not affect word/word_valid.
- Non-zero start lane (sel_in != 0): the frame still completes after WIDTH accepted bits; sel wraps through all lanes.
- Output handshake:
  - word_valid && word_ready: word_valid falls next cycle unless a new frame completes in the same cycle.
  - Simultaneous accept and completion: the new word loads and word_valid stays 1 (back-to-back, no bubble).
- Holding full and not ready when a frame completes: the new word is dropped, word is unchanged, overflow <= 1.
  - overflow clears only on reset.
- din_valid=0: no state change; lane=0.
- word is stable while word_valid=1 and not accepted.

Optional Feature:
- Macro: DEMUX_DESER_PARITY_EN.
- Defined:
  - Frame is WIDTH+1 accepted bits; the last bit is an even-parity bit and is not written to asm.
  - sel_out holds at its wrapped value during the parity bit.
  - At completion, parity_err = ^word ^ parity_bit. It is updated with word and held with it.
- Undefined: frame is WIDTH bits and parity_err is tied 0.

Decomposition:
- Shared package demux_pkg:
  - localparam DEMUX_WIDTH_DEF=8.
  - Function for SEL_W computation.
  - Typedef of the holding state enum {HOLD_EMPTY, HOLD_FULL}.
- One sub-module, demux_hold_reg: single-entry valid/ready skid register with drop/overflow flag.
- The select counter and assembly stay in the top.

Test Plan:
- Reset, then sel_load=1 with sel_in=0; bits 0,1,0,1,1,0,1,0 with din_valid=1 and word_ready=1 -> one cycle after the 8th bit, word=8'b01011010 and word_valid=1 for one cycle; sel_out back to 0.
- lane check: sel_out=3, din=1, din_valid=1 -> lane=8'b00001000; din_valid=0 -> lane=8'h00.
- sel_load with sel_in=5, then 8 ones -> sel_out sequence 5,6,7,0..4; word=8'hFF; sel_out=5 after completion.
- word_ready=0, two full frames (8'hA5 then 8'h3C) -> word stays 8'hA5 and overflow=1.
  - Then word_ready=1 -> word_valid drops next cycle; overflow still 1.
- rst_n=0 after 4 bits, then 8 bits of 8'h81 -> word=8'h81, with no leakage of the earlier partial bits.
- With DEMUX_DESER_PARITY_EN: 8'hA5 plus parity 0 -> parity_err=0; 8'hA5 plus parity 1 -> parity_err=1.
